// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: stall holds, flush inserts a bubble, invalid decode slots
// load with their control lines killed, and a saturating counter tracks inserted bubbles.
module idex_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ID_Stall,
  input  logic                  ID_Flush,
  input  logic                  ID_Valid,
  input  logic                  ID_RegWrite,
  input  logic                  ID_CondMov,
  input  logic                  ID_MemtoReg,
  input  logic                  ID_MemWrite,
  input  logic                  ID_MemRead,
  input  logic                  ID_RegDst,
  input  logic                  ID_ALUSrc1,
  input  logic                  ID_ALUSrc2,
  input  logic [ALUOP_W-1:0]    ID_ALUOp,
  input  logic [DATA_W-1:0]     ID_PCAddResult,
  input  logic [DATA_W-1:0]     ID_ReadData1,
  input  logic [DATA_W-1:0]     ID_ReadData2,
  input  logic [DATA_W-1:0]     ID_immExt,
  input  logic [DATA_W-1:0]     ID_sa,
  input  logic [REG_ADDR_W-1:0] ID_rs,
  input  logic [REG_ADDR_W-1:0] ID_rt,
  input  logic [REG_ADDR_W-1:0] ID_rd,
  output logic                  EX_Valid,
  output logic                  EX_RegWrite,
  output logic                  EX_CondMov,
  output logic                  EX_MemtoReg,
  output logic                  EX_MemWrite,
  output logic                  EX_MemRead,
  output logic                  EX_RegDst,
  output logic                  EX_ALUSrc1,
  output logic                  EX_ALUSrc2,
  output logic [ALUOP_W-1:0]    EX_ALUOp,
  output logic [DATA_W-1:0]     EX_PCAddResult,
  output logic [DATA_W-1:0]     EX_ReadData1,
  output logic [DATA_W-1:0]     EX_ReadData2,
  output logic [DATA_W-1:0]     EX_immExt,
  output logic [DATA_W-1:0]     EX_sa,
  output logic [REG_ADDR_W-1:0] EX_rs,
  output logic [REG_ADDR_W-1:0] EX_rt,
  output logic [REG_ADDR_W-1:0] EX_rd,
  output logic [CNT_W-1:0]      EX_BubbleCount
);

  localparam int CTRL_W = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  endfunction

  logic [CTRL_W-1:0]     ctrl_in;
  logic                  vld_p1;
  logic [CTRL_W-1:0]     ctrl_p1;
  logic [ALUOP_W-1:0]    alu_op_p1;
  logic [DATA_W-1:0]     pc_add_p1;
  logic [DATA_W-1:0]     rd_data1_p1;
  logic [DATA_W-1:0]     rd_data2_p1;
  logic [DATA_W-1:0]     imm_ext_p1;
  logic [DATA_W-1:0]     sa_p1;
  logic [REG_ADDR_W-1:0] rs_p1;
  logic [REG_ADDR_W-1:0] rt_p1;
  logic [REG_ADDR_W-1:0] rd_p1;
  logic [CNT_W-1:0]      bubble_cnt_p1;

  assign ctrl_in = {ID_RegWrite, ID_CondMov, ID_MemtoReg, ID_MemWrite,
                    ID_MemRead, ID_RegDst, ID_ALUSrc1, ID_ALUSrc2};

  // ID -> EX stage boundary
  always_ff @(posedge Clk) begin
    if (Reset || ID_Flush) begin
      vld_p1        <= 1'b0;
      ctrl_p1       <= '0;
      alu_op_p1     <= '0;
      pc_add_p1     <= '0;
      rd_data1_p1   <= '0;
      rd_data2_p1   <= '0;
      imm_ext_p1    <= '0;
      sa_p1         <= '0;
      rs_p1         <= '0;
      rt_p1         <= '0;
      rd_p1         <= '0;
      bubble_cnt_p1 <= Reset ? '0 : sat_inc(bubble_cnt_p1);
    end else if (!ID_Stall) begin
      vld_p1        <= ID_Valid;
      // an invalid slot must never write registers or touch memory
      ctrl_p1       <= ID_Valid ? ctrl_in : '0;
      alu_op_p1     <= ID_ALUOp;
      pc_add_p1     <= ID_PCAddResult;
      rd_data1_p1   <= ID_ReadData1;
      rd_data2_p1   <= ID_ReadData2;
      imm_ext_p1    <= ID_immExt;
      sa_p1         <= ID_sa;
      rs_p1         <= ID_rs;
      rt_p1         <= ID_rt;
      rd_p1         <= ID_rd;
      if (!ID_Valid)
        bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
    end
  end

  assign EX_Valid = vld_p1;
  assign {EX_RegWrite, EX_CondMov, EX_MemtoReg, EX_MemWrite,
          EX_MemRead, EX_RegDst, EX_ALUSrc1, EX_ALUSrc2} = ctrl_p1;
  assign EX_ALUOp       = alu_op_p1;
  assign EX_PCAddResult = pc_add_p1;
  assign EX_ReadData1   = rd_data1_p1;
  assign EX_ReadData2   = rd_data2_p1;
  assign EX_immExt      = imm_ext_p1;
  assign EX_sa          = sa_p1;
  assign EX_rs          = rs_p1;
  assign EX_rt          = rt_p1;
  assign EX_rd          = rd_p1;
  assign EX_BubbleCount = bubble_cnt_p1;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Bench for idex_pipe_reg: vector table plus hand sequences, expectations queued per edge.
module tb_idex_pipe_reg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int OW = 5;
  localparam int CW = 4;

  typedef struct packed {
    logic rst, flush, stall, valid;
    logic [7:0]    ctrl;
    logic [OW-1:0] alu;
    logic [DW-1:0] pc, rd1, rd2, imm, sa;
    logic [AW-1:0] rs, rt, rd;
  } in_t;

  typedef struct packed {
    logic          vld;
    logic [7:0]    ctrl;
    logic [OW-1:0] alu;
    logic [DW-1:0] pc, rd1, rd2, imm, sa;
    logic [AW-1:0] rs, rt, rd;
    logic [CW-1:0] cnt;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic Clk, Reset, ID_Stall, ID_Flush, ID_Valid;
  logic ID_RegWrite, ID_CondMov, ID_MemtoReg, ID_MemWrite, ID_MemRead, ID_RegDst, ID_ALUSrc1, ID_ALUSrc2;
  logic [OW-1:0] ID_ALUOp;
  logic [DW-1:0] ID_PCAddResult, ID_ReadData1, ID_ReadData2, ID_immExt, ID_sa;
  logic [AW-1:0] ID_rs, ID_rt, ID_rd;
  logic EX_Valid, EX_RegWrite, EX_CondMov, EX_MemtoReg, EX_MemWrite, EX_MemRead, EX_RegDst, EX_ALUSrc1, EX_ALUSrc2;
  logic [OW-1:0] EX_ALUOp;
  logic [DW-1:0] EX_PCAddResult, EX_ReadData1, EX_ReadData2, EX_immExt, EX_sa;
  logic [AW-1:0] EX_rs, EX_rt, EX_rd;
  logic [CW-1:0] EX_BubbleCount;

  int   tests = 0;
  int   fails = 0;
  out_t exp_q[$];
  vec_t vecs[12];

  idex_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .ALUOP_W(OW), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .ID_Stall(ID_Stall), .ID_Flush(ID_Flush), .ID_Valid(ID_Valid),
    .ID_RegWrite(ID_RegWrite), .ID_CondMov(ID_CondMov), .ID_MemtoReg(ID_MemtoReg),
    .ID_MemWrite(ID_MemWrite), .ID_MemRead(ID_MemRead), .ID_RegDst(ID_RegDst),
    .ID_ALUSrc1(ID_ALUSrc1), .ID_ALUSrc2(ID_ALUSrc2), .ID_ALUOp(ID_ALUOp),
    .ID_PCAddResult(ID_PCAddResult), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_immExt(ID_immExt), .ID_sa(ID_sa), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
    .EX_Valid(EX_Valid), .EX_RegWrite(EX_RegWrite), .EX_CondMov(EX_CondMov),
    .EX_MemtoReg(EX_MemtoReg), .EX_MemWrite(EX_MemWrite), .EX_MemRead(EX_MemRead),
    .EX_RegDst(EX_RegDst), .EX_ALUSrc1(EX_ALUSrc1), .EX_ALUSrc2(EX_ALUSrc2), .EX_ALUOp(EX_ALUOp),
    .EX_PCAddResult(EX_PCAddResult), .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
    .EX_immExt(EX_immExt), .EX_sa(EX_sa), .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd),
    .EX_BubbleCount(EX_BubbleCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic in_t mk_in(logic rst, logic flush, logic stall, logic valid, logic [7:0] ctrl,
                                logic [OW-1:0] alu, logic [DW-1:0] pc, logic [DW-1:0] rd1,
                                logic [DW-1:0] rd2, logic [DW-1:0] imm, logic [DW-1:0] sa,
                                logic [AW-1:0] rs, logic [AW-1:0] rt, logic [AW-1:0] rd);
    return '{rst, flush, stall, valid, ctrl, alu, pc, rd1, rd2, imm, sa, rs, rt, rd};
  endfunction

  function automatic out_t mk_out(logic vld, logic [7:0] ctrl, logic [OW-1:0] alu, logic [DW-1:0] pc,
                                  logic [DW-1:0] rd1, logic [DW-1:0] rd2, logic [DW-1:0] imm,
                                  logic [DW-1:0] sa, logic [AW-1:0] rs, logic [AW-1:0] rt,
                                  logic [AW-1:0] rd, logic [CW-1:0] cnt);
    return '{vld, ctrl, alu, pc, rd1, rd2, imm, sa, rs, rt, rd, cnt};
  endfunction

  task automatic apply(input in_t v);
    Reset = v.rst; ID_Flush = v.flush; ID_Stall = v.stall; ID_Valid = v.valid;
    {ID_RegWrite, ID_CondMov, ID_MemtoReg, ID_MemWrite, ID_MemRead, ID_RegDst, ID_ALUSrc1, ID_ALUSrc2} = v.ctrl;
    ID_ALUOp = v.alu; ID_PCAddResult = v.pc; ID_ReadData1 = v.rd1; ID_ReadData2 = v.rd2;
    ID_immExt = v.imm; ID_sa = v.sa; ID_rs = v.rs; ID_rt = v.rt; ID_rd = v.rd;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic cmp_out(input string tag, input out_t e);
    check({tag, ".valid"}, 32'(EX_Valid), 32'(e.vld));
    check({tag, ".ctrl"}, 32'({EX_RegWrite, EX_CondMov, EX_MemtoReg, EX_MemWrite,
                               EX_MemRead, EX_RegDst, EX_ALUSrc1, EX_ALUSrc2}), 32'(e.ctrl));
    check({tag, ".aluop"}, 32'(EX_ALUOp), 32'(e.alu));
    check({tag, ".pc"}, EX_PCAddResult, e.pc);
    check({tag, ".rd1"}, EX_ReadData1, e.rd1);
    check({tag, ".rd2"}, EX_ReadData2, e.rd2);
    check({tag, ".imm"}, EX_immExt, e.imm);
    check({tag, ".sa"}, EX_sa, e.sa);
    check({tag, ".regs"}, 32'({EX_rs, EX_rt, EX_rd}), 32'({e.rs, e.rt, e.rd}));
    check({tag, ".bubbles"}, 32'(EX_BubbleCount), 32'(e.cnt));
    if (EX_Valid === 1'b0)
      check({tag, ".inv_kill"}, 32'({EX_RegWrite, EX_MemWrite, EX_MemRead, EX_CondMov}), 32'd0);
  endtask

  task automatic step(input string tag, input in_t v, input out_t e);
    out_t x;
    apply(v);
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      x = exp_q.pop_front();
      cmp_out(tag, x);
    end
  endtask

  initial begin
    out_t z;
    in_t  v;
    z = '0;
    // reset with garbage on every input
    vecs[0]  = '{mk_in(1,0,0,1,8'hFF,5'h1F,32'hFFFFFFFF,32'hFFFFFFFF,32'hFFFFFFFF,32'hFFFFFFFF,32'hFFFFFFFF,5'h1F,5'h1F,5'h1F), z};
    vecs[1]  = '{mk_in(0,0,0,1,8'h80,5'h0A,32'h4,32'hDEADBEEF,32'h0,32'h0,32'h0,5'd3,5'd7,5'd0),
                 mk_out(1,8'h80,5'h0A,32'h4,32'hDEADBEEF,32'h0,32'h0,32'h0,5'd3,5'd7,5'd0,4'd0)};
    vecs[2]  = '{mk_in(0,0,0,1,8'h06,5'h01,32'h8,32'h1,32'h1234,32'h5,32'h2,5'd1,5'd2,5'd4),
                 mk_out(1,8'h06,5'h01,32'h8,32'h1,32'h1234,32'h5,32'h2,5'd1,5'd2,5'd4,4'd0)};
    for (int k = 3; k <= 5; k++)
      vecs[k] = '{mk_in(0,0,1,k[0],8'hFF,5'h1F,32'hFFFF,32'hFFFF,32'hFFFF,32'hFFFF,32'hFFFF,5'h1F,5'h1F,5'h1F),
                  mk_out(1,8'h06,5'h01,32'h8,32'h1,32'h1234,32'h5,32'h2,5'd1,5'd2,5'd4,4'd0)};
    vecs[6]  = '{mk_in(0,0,0,1,8'h01,5'h02,32'hC,32'hFFFF,32'hFFFF,32'hFFFF,32'hFFFF,5'h1F,5'h1F,5'h1F),
                 mk_out(1,8'h01,5'h02,32'hC,32'hFFFF,32'hFFFF,32'hFFFF,32'hFFFF,5'h1F,5'h1F,5'h1F,4'd0)};
    vecs[7]  = '{mk_in(1'b0,1,1,1,8'h10,5'h07,32'h10,32'h11,32'h22,32'h33,32'h4,5'd9,5'd10,5'd11),
                 mk_out(0,8'h00,5'h00,32'h0,32'h0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,4'd1)};
    vecs[8]  = '{mk_in(0,0,0,0,8'h88,5'h00,32'h10,32'hAA,32'hBB,32'h10,32'h3,5'd5,5'd6,5'd7),
                 mk_out(0,8'h00,5'h00,32'h10,32'hAA,32'hBB,32'h10,32'h3,5'd5,5'd6,5'd7,4'd2)};
    vecs[9]  = '{mk_in(0,0,1,1,8'hFF,5'h1F,32'h1,32'h2,32'h3,32'h4,32'h5,5'd1,5'd1,5'd1),
                 mk_out(0,8'h00,5'h00,32'h10,32'hAA,32'hBB,32'h10,32'h3,5'd5,5'd6,5'd7,4'd2)};
    vecs[10] = '{mk_in(0,0,0,1,8'h5A,5'h15,32'h14,32'hFFFFFFFF,32'h80000000,32'hFFFF8000,32'h1F,5'h1F,5'h00,5'h1F),
                 mk_out(1,8'h5A,5'h15,32'h14,32'hFFFFFFFF,32'h80000000,32'hFFFF8000,32'h1F,5'h1F,5'h00,5'h1F,4'd2)};
    vecs[11] = '{mk_in(0,0,0,0,8'hFF,5'h00,32'h0,32'h0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0),
                 mk_out(0,8'h00,5'h00,32'h0,32'h0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,4'd3)};

    for (int k = 0; k < 12; k++)
      step($sformatf("vec%0d", k), vecs[k].i, vecs[k].o);

    // saturation: 17 flushes from reset, counter sticks at 15
    step("sat_rst", mk_in(1,0,0,0,8'h00,5'h0,32'h0,32'h0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0), z);
    for (int k = 1; k <= 17; k++) begin
      v = mk_in(0,1,k[0],1,8'hFF,5'h1F,32'h5,32'h6,32'h7,32'h8,32'h9,5'd1,5'd2,5'd3);
      step($sformatf("sat_flush%0d", k), v,
           mk_out(0,8'h00,5'h00,32'h0,32'h0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0, (k >= 15) ? 4'd15 : CW'(k)));
    end
    step("sat_nat", mk_in(0,0,0,0,8'hFF,5'h00,32'h1,32'h2,32'h3,32'h4,32'h5,5'd1,5'd2,5'd3),
         mk_out(0,8'h00,5'h00,32'h1,32'h2,32'h3,32'h4,32'h5,5'd1,5'd2,5'd3,4'd15));

    // reset arriving mid-stall together with a flush clears everything, no increment
    v = mk_in(0,0,0,1,8'h21,5'h03,32'h40,32'h41,32'h42,32'h43,32'h44,5'd8,5'd9,5'd10);
    step("rs_load", v, mk_out(1,8'h21,5'h03,32'h40,32'h41,32'h42,32'h43,32'h44,5'd8,5'd9,5'd10,4'd15));
    step("rs_stall", mk_in(0,0,1,0,8'hFF,5'h1F,32'h0,32'h0,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0),
         mk_out(1,8'h21,5'h03,32'h40,32'h41,32'h42,32'h43,32'h44,5'd8,5'd9,5'd10,4'd15));
    step("rs_rst_flush", mk_in(1,1,1,1,8'hFF,5'h1F,32'h9,32'h9,32'h9,32'h9,32'h9,5'd9,5'd9,5'd9), z);
    step("rs_after", v, mk_out(1,8'h21,5'h03,32'h40,32'h41,32'h42,32'h43,32'h44,5'd8,5'd9,5'd10,4'd0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
